// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the LCD RGB receiver.
// Holds the receiver FSM states, default geometry and a saturating counter helper.
package lcd_rx_pkg;

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_DE,
        ACTIVE
    } rx_state_t;

    localparam int DEF_W = 800;
    localparam int DEF_H = 480;
    localparam int CW    = 11;

    localparam logic [CW-1:0] CNT_MAX = '1;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

endpackage

// File: rtl/lcd_rx_sync.sv
// Two-stage input registers and edge detection for the LCD receiver.
// Ports: clk, rst_n, raw lcd_* inputs in; stage-1 samples (syncs active-high) and edges out.
module lcd_rx_sync #(
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_hs,
    input  logic        lcd_vs,
    input  logic        lcd_de,
    input  logic [23:0] lcd_rgb,
    output logic        s1_hs,
    output logic        s1_vs,
    output logic        s1_de,
    output logic [23:0] s1_rgb,
    output logic        vs_rise,
    output logic        de_rise,
    output logic        de_fall
);

    // Syncs are normalised so that 1 always means "asserted".
    localparam logic POL = (SYNC_ACTIVE_LOW != 0);

    logic s2_vs;
    logic s2_de;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_de  <= 1'b0;
            s1_rgb <= '0;
            s2_vs  <= 1'b0;
            s2_de  <= 1'b0;
        end else begin
            s1_hs  <= lcd_hs ^ POL;
            s1_vs  <= lcd_vs ^ POL;
            s1_de  <= lcd_de;
            s1_rgb <= lcd_rgb;
            s2_vs  <= s1_vs;
            s2_de  <= s1_de;
        end
    end

    assign vs_rise = s1_vs & ~s2_vs;
    assign de_rise = s1_de & ~s2_de;
    assign de_fall = ~s1_de & s2_de;

endmodule

// File: rtl/lcd_rgb_rx.sv
// LCD parallel RGB receiver: emits pixels with position and per-frame geometry results.
// Ports: clk, rst_n, lcd_hs/vs/de/rgb in; pixel_*, frame_start/done, geometry and frame_sum out.
// Optional: define LCD_RX_SUM_EN to build the per-frame pixel sum; otherwise frame_sum is 0.
module lcd_rgb_rx
    import lcd_rx_pkg::*;
#(
    parameter int EXP_W           = DEF_W,
    parameter int EXP_H           = DEF_H,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_hs,
    input  logic        lcd_vs,
    input  logic        lcd_de,
    input  logic [23:0] lcd_rgb,
    output logic        pixel_valid,
    output logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        frame_start,
    output logic        frame_done,
    output logic [10:0] active_width,
    output logic [10:0] active_height,
    output logic        geom_err,
    output logic [23:0] frame_sum
);

    localparam logic [CW-1:0] EW = CW'(EXP_W);
    localparam logic [CW-1:0] EH = CW'(EXP_H);

    logic        s1_hs, s1_vs, s1_de;
    logic [23:0] s1_rgb;
    logic        vs_rise, de_rise, de_fall;

    lcd_rx_sync #(
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .lcd_hs (lcd_hs),
        .lcd_vs (lcd_vs),
        .lcd_de (lcd_de),
        .lcd_rgb(lcd_rgb),
        .s1_hs  (s1_hs),
        .s1_vs  (s1_vs),
        .s1_de  (s1_de),
        .s1_rgb (s1_rgb),
        .vs_rise(vs_rise),
        .de_rise(de_rise),
        .de_fall(de_fall)
    );

    rx_state_t     state, state_nxt;
    logic          emit, live, close, line_end, new_err;
    logic [CW-1:0] x_cnt, y_cnt, w_acc;
    logic [CW-1:0] w_pend, h_pend;
    logic          err_acc, err_pend, done_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_VS;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        unique case (state)
            WAIT_VS: begin
                if (vs_rise) state_nxt = WAIT_DE;
            end
            WAIT_DE: begin
                if (vs_rise) begin
                    state_nxt = WAIT_DE;
                end else if (de_rise && !s1_vs) begin
                    state_nxt = ACTIVE;
                    emit      = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) state_nxt = WAIT_DE;
                else         emit      = s1_de & ~s1_vs;
            end
            default: state_nxt = WAIT_VS;
        endcase
    end

    assign live     = (state != WAIT_VS);
    assign close    = vs_rise & (state == ACTIVE);
    assign line_end = de_fall & (state == ACTIVE);

    // Line 0 defines the width; every later line is compared against it.
    assign new_err = (live & s1_de & (s1_vs | s1_hs))
                   | (emit & (x_cnt == CNT_MAX))
                   | (line_end & (y_cnt == CNT_MAX))
                   | (line_end & (y_cnt != '0) & (x_cnt != w_acc));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            w_acc   <= '0;
            err_acc <= 1'b0;
        end else if (vs_rise) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            w_acc   <= '0;
            err_acc <= s1_de;
        end else if (live) begin
            err_acc <= err_acc | new_err;
            if (emit) x_cnt <= sat_inc(x_cnt);
            if (line_end) begin
                x_cnt <= '0;
                y_cnt <= sat_inc(y_cnt);
                if (y_cnt == '0) w_acc <= x_cnt;
            end
        end
    end

    // Results are snapshotted at the closing vs edge, since the
    // accumulators restart for the new frame on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_valid   <= 1'b0;
            pixel_data    <= '0;
            pixel_xpos    <= '0;
            pixel_ypos    <= '0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            done_pend     <= 1'b0;
            w_pend        <= '0;
            h_pend        <= '0;
            err_pend      <= 1'b0;
            active_width  <= '0;
            active_height <= '0;
            geom_err      <= 1'b0;
        end else begin
            pixel_valid <= emit;
            frame_start <= vs_rise;
            done_pend   <= close;
            frame_done  <= done_pend;
            if (emit) begin
                pixel_data <= s1_rgb;
                pixel_xpos <= x_cnt;
                pixel_ypos <= y_cnt;
            end
            if (close) begin
                w_pend   <= w_acc;
                h_pend   <= y_cnt;
                err_pend <= err_acc | (w_acc != EW) | (y_cnt != EH);
            end
            if (done_pend) begin
                active_width  <= w_pend;
                active_height <= h_pend;
                geom_err      <= err_pend;
            end
        end
    end

`ifdef LCD_RX_SUM_EN
    logic [23:0] sum_acc, sum_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_acc   <= '0;
            sum_pend  <= '0;
            frame_sum <= '0;
        end else begin
            if (vs_rise)   sum_acc <= '0;
            else if (emit) sum_acc <= sum_acc + s1_rgb;
            if (close)     sum_pend  <= sum_acc;
            if (done_pend) frame_sum <= sum_pend;
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Self-checking bench for lcd_rgb_rx using a small 8x6 expected geometry.
// Frame-level model predicts every output cycle; literal checks pin key results.
module tb_lcd_rgb_rx;

    localparam int W = 8;
    localparam int H = 6;
`ifdef LCD_RX_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        lcd_hs  = 1'b1;
    logic        lcd_vs  = 1'b1;
    logic        lcd_de  = 1'b0;
    logic [23:0] lcd_rgb = '0;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic        frame_start, frame_done;
    logic [10:0] active_width, active_height;
    logic        geom_err;
    logic [23:0] frame_sum;

    lcd_rgb_rx #(
        .EXP_W(W),
        .EXP_H(H),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lcd_hs       (lcd_hs),
        .lcd_vs       (lcd_vs),
        .lcd_de       (lcd_de),
        .lcd_rgb      (lcd_rgb),
        .pixel_valid  (pixel_valid),
        .pixel_data   (pixel_data),
        .pixel_xpos   (pixel_xpos),
        .pixel_ypos   (pixel_ypos),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .active_width (active_width),
        .active_height(active_height),
        .geom_err     (geom_err),
        .frame_sum    (frame_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tgt;
        bit          v;
        logic [23:0] d;
        int          x, y;
        bit          fs, fd;
        int          w, h;
        bit          e;
        logic [23:0] s;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          chk_en = 0;
    bit          armed = 0, fd_pend = 0, pix_const = 0, pix_mark = 0;
    int          open_lens[$];
    logic [23:0] open_sum = '0;
    bit          open_err = 0;
    int          pw = 0, ph = 0;
    bit          pe = 0;
    logic [23:0] ps = '0;
    int          mw = 0, mh = 0;
    bit          me = 0;
    logic [23:0] ms = '0;
    int          drv_mark = -1, mon_cyc = -1, mon_x = -1, mon_y = -1;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int x, input int y);
        if (pix_const) return 24'h000001;
        if (pix_mark && x == 0 && y == 0) return 24'hABCDEF;
        return 24'((y << 16) + (x << 8) + 60 + x * y);
    endfunction

    task automatic drive(input bit hs, input bit vs, input bit de,
                         input logic [23:0] rgb, input bit ev,
                         input int ex, input int ey, input bit efs);
        exp_t r;
        lcd_hs  = ~hs;
        lcd_vs  = ~vs;
        lcd_de  = de;
        lcd_rgb = rgb;
        r.tgt = cyc + 2;
        r.v   = ev;
        r.d   = rgb;
        r.x   = ex;
        r.y   = ey;
        r.fs  = efs;
        r.fd  = fd_pend;
        r.w   = pw;
        r.h   = ph;
        r.e   = pe;
        r.s   = ps;
        fd_pend = 0;
        exp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 24'h0, 0, 0, 0, 0);
    endtask

    task automatic line(input int len, input bit hs_bad, input bit tail);
        int          y;
        logic [23:0] d;
        y = open_lens.size();
        for (int x = 0; x < len; x++) begin
            d = pix(x, y);
            if (pix_mark && d == 24'hABCDEF) drv_mark = cyc;
            drive(hs_bad && (x == len / 2), 0, 1, d, armed, x, y, 0);
            if (armed) open_sum += d;
        end
        if (armed && len > 0) begin
            open_lens.push_back(len);
            open_err |= hs_bad;
        end
        if (tail) begin
            drive(0, 0, 0, 24'h0, 0, 0, 0, 0);
            drive(1, 0, 0, 24'h0, 0, 0, 0, 0);
            drive(0, 0, 0, 24'h0, 0, 0, 0, 0);
        end
    endtask

    task automatic vsync();
        bit cl;
        cl = armed && (open_lens.size() > 0);
        if (cl) begin
            pw = open_lens[0];
            ph = open_lens.size();
            pe = open_err || (ph != H);
            foreach (open_lens[i]) if (open_lens[i] != W) pe = 1;
            ps = SUM_EN ? open_sum : 24'h0;
        end
        drive(0, 1, 0, 24'h0, 0, 0, 0, 1);
        fd_pend = cl;
        drive(0, 1, 0, 24'h0, 0, 0, 0, 0);
        drive(0, 0, 0, 24'h0, 0, 0, 0, 0);
        drive(0, 0, 0, 24'h0, 0, 0, 0, 0);
        armed = 1;
        open_lens.delete();
        open_sum = '0;
        open_err = 0;
    endtask

    task automatic frame(input int nl, input int short_y, input int hs_y);
        for (int y = 0; y < nl; y++)
            line((y == short_y) ? W - 1 : W, y == hs_y, 1);
    endtask

    task automatic do_reset();
        chk_en = 0;
        rst_n  = 0;
        #1;
        chk("rst_valid", 32'(pixel_valid), 0);
        chk("rst_data", 32'(pixel_data), 0);
        chk("rst_xpos", 32'(pixel_xpos), 0);
        chk("rst_ypos", 32'(pixel_ypos), 0);
        chk("rst_fstart", 32'(frame_start), 0);
        chk("rst_fdone", 32'(frame_done), 0);
        chk("rst_width", 32'(active_width), 0);
        chk("rst_height", 32'(active_height), 0);
        chk("rst_err", 32'(geom_err), 0);
        chk("rst_sum", 32'(frame_sum), 0);
        armed   = 0;
        fd_pend = 0;
        open_lens.delete();
        open_sum = '0;
        open_err = 0;
        mw = 0;
        mh = 0;
        me = 0;
        ms = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        exp_q.delete();
        chk_en = 1;
    endtask

    always @(negedge clk) begin
        exp_t r;
        if (chk_en) begin
            while (exp_q.size() > 0 && exp_q[0].tgt < cyc)
                void'(exp_q.pop_front());
            if (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
                r = exp_q.pop_front();
                if (r.fd) begin
                    mw = r.w;
                    mh = r.h;
                    me = r.e;
                    ms = r.s;
                end
                chk("pixel_valid", 32'(pixel_valid), 32'(r.v));
                chk("frame_start", 32'(frame_start), 32'(r.fs));
                chk("frame_done", 32'(frame_done), 32'(r.fd));
                chk("active_width", 32'(active_width), mw);
                chk("active_height", 32'(active_height), mh);
                chk("geom_err", 32'(geom_err), 32'(me));
                chk("frame_sum", 32'(frame_sum), 32'(ms));
                if (r.v) begin
                    chk("pixel_data", 32'(pixel_data), 32'(r.d));
                    chk("pixel_xpos", 32'(pixel_xpos), r.x);
                    chk("pixel_ypos", 32'(pixel_ypos), r.y);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (pixel_valid && pixel_data == 24'hABCDEF && mon_cyc < 0) begin
            mon_cyc = cyc;
            mon_x   = int'(pixel_xpos);
            mon_y   = int'(pixel_ypos);
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        line(W, 0, 1);
        line(W, 0, 1);
        idle(3);
        vsync();

        pix_const = 1;
        frame(H, -1, -1);
        vsync();
        frame(H, -1, -1);
        vsync();
        chk("clean_width", 32'(active_width), W);
        chk("clean_height", 32'(active_height), H);
        chk("clean_err", 32'(geom_err), 0);
        chk("clean_sum", 32'(frame_sum), SUM_EN ? 48 : 0);
        pix_const = 0;

        frame(H, 5, -1);
        vsync();
        chk("short_err", 32'(geom_err), 1);
        chk("short_width", 32'(active_width), W);
        chk("short_height", 32'(active_height), H);

        vsync();
        chk("empty_keep_err", 32'(geom_err), 1);

        pix_mark = 1;
        frame(H, -1, 3);
        pix_mark = 0;
        vsync();
        chk("mark_latency", mon_cyc - drv_mark, 2);
        chk("mark_x", mon_x, 0);
        chk("mark_y", mon_y, 0);
        chk("hs_err", 32'(geom_err), 1);

        line(W, 0, 1);
        line(W, 0, 1);
        line(3, 0, 0);
        do_reset();
        line(5, 0, 1);
        line(W, 0, 1);
        vsync();
        frame(H, -1, -1);
        vsync();
        chk("post_rst_width", 32'(active_width), W);
        chk("post_rst_height", 32'(active_height), H);
        chk("post_rst_err", 32'(geom_err), 0);

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_rgb_rx.md
LCD_RGB_RX -- requirements
Module: lcd_rgb_rx

Interface
REQ-001 Parameter EXP_W, default 800, expected active pixels per line.
REQ-002 Parameter EXP_H, default 480, expected active lines per frame.
REQ-003 Parameter SYNC_ACTIVE_LOW, default 1; 1 = lcd_hs/lcd_vs asserted low, 0 = asserted high.
REQ-004 clk  input  1  pixel clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 lcd_hs  input  1  line sync.
REQ-007 lcd_vs  input  1  frame sync.
REQ-008 lcd_de  input  1  active-pixel enable.
REQ-009 lcd_rgb  input  24  pixel data, R[23:16] G[15:8] B[7:0].
REQ-010 pixel_valid  output  1  one-cycle qualifier per received active pixel.
REQ-011 pixel_data  output  24  received pixel.
REQ-012 pixel_xpos  output  11  column of pixel_data, 0-based.
REQ-013 pixel_ypos  output  11  line of pixel_data, 0-based.
REQ-014 frame_start  output  1  one-cycle pulse on frame-sync assertion.
REQ-015 frame_done  output  1  one-cycle pulse when a completed frame's results update.
REQ-016 active_width  output  11  width of first line of last completed frame.
REQ-017 active_height  output  11  line count of last completed frame.
REQ-018 geom_err  output  1  sticky-per-frame geometry error of last completed frame.
REQ-019 frame_sum  output  24  sum of all pixels of last completed frame, mod 2^24 (LCD_RX_SUM_EN only).

Function
REQ-020 Inputs registered once (stage 1), then again (stage 2); edges = stage-1 vs stage-2 comparison.
REQ-021 Pixel outputs registered: lcd_de high at edge N -> pixel_valid high at edge N+2 with that lcd_rgb; latency exactly 2 cycles.
REQ-022 FSM states WAIT_VS, WAIT_DE, ACTIVE; reset enters WAIT_VS.
REQ-023 WAIT_VS: all de ignored, no pixel_valid; vs assertion edge -> WAIT_DE.
REQ-024 WAIT_DE: first de rising edge -> ACTIVE.
REQ-025 Any vs assertion edge: frame_start pulses same cycle pixel outputs would for that sample; x, y, width, error, sum accumulators cleared.
REQ-026 vs assertion from ACTIVE: frame_done pulses one cycle after frame_start; active_width, active_height, geom_err, frame_sum update same cycle; then WAIT_DE.
REQ-027 vs assertion from WAIT_DE (zero active lines): frame_start only; no frame_done, results unchanged.
REQ-028 x increments per valid pixel, returns to 0 on de falling edge; y increments on de falling edge.
REQ-029 x and y saturate at 2047; saturation sets frame error.
REQ-030 First line's pixel count captured as frame width; any later line differing, or width != EXP_W, or final height != EXP_H, sets frame error.
REQ-031 de high while vs asserted: pixel not emitted, frame error set.
REQ-032 hs carries no counting function; hs asserted during de sets frame error.

Reset
REQ-033 rst_n low: FSM WAIT_VS, all outputs 0, all counters/accumulators 0, regardless of clk.
REQ-034 Reset mid-frame discards the partial frame; results reported only after a full subsequent frame.

Configuration
REQ-035 Macro LCD_RX_SUM_EN defined: frame_sum accumulates pixel_data each pixel_valid, mod 2^24, reported per REQ-026.
REQ-036 LCD_RX_SUM_EN undefined: no accumulator logic; frame_sum tied to 0.

Structure
REQ-037 Package lcd_rx_pkg holds FSM state enum and default geometry constants 800/480.
REQ-038 Sub-module lcd_rx_sync holds the two-stage input registers and edge detection.

Verification
REQ-039 Reset, then two 800x480 frames constant 0x000001, EXP defaults -> second-frame frame_done: width 800, height 480, geom_err 0, frame_sum 384000.
REQ-040 de asserted before any vs after reset -> no pixel_valid, no frame_done.
REQ-041 Line 5 carries 799 pixels, rest 800 -> geom_err 1, active_width 800, active_height 480.
REQ-042 Single pixel 0xABCDEF at first active position -> pixel_valid exactly 2 cycles later, data 0xABCDEF, xpos 0, ypos 0.
REQ-043 rst_n pulsed low mid-line 200 -> outputs 0 immediately; next full frame reports clean results.
REQ-044 Build without LCD_RX_SUM_EN, repeat REQ-039 -> frame_sum 0, other results identical.
